// File: rtl/bus_pkg.sv
// Shared definitions for the daisy-chained register bus.
package bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // One beat on the chain. This type is shared with the cores further down the chain.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rw;
    logic              valid;
  } bus_xact_t;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter that flags a lost transaction once TIMEOUT cycles have elapsed.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count cycles while enabled. The counter saturates and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Flag expiry in the last allowed cycle so that the owner can leave on the next edge.
  always_comb begin
    expired = enable && (r_count == LAST);
  end

endmodule

// File: rtl/bus_initiator.sv
// Head-end master: launches one host request into the chain and returns the tail echo.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              req_rw_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_rw_o,
  output logic              resp_timeout_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [DATA_W-1:0] bus_rdata_o,
  output logic              bus_rw_o,
  output logic              bus_valid_o,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_rw_i,
  input  logic              bus_valid_i,
  output logic              mismatch_o
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_rw;
  logic              r_resp_timeout;
  logic              r_mismatch;
  logic              w_match;
  logic              w_outstanding;
  logic              w_expired;
  bus_xact_t         w_head;
  logic              w_unused_wdata;

  // The host has no use for the write data that the tail echoes back.
  assign w_unused_wdata = ^bus_wdata_i;

  assign w_outstanding = (r_state == ISSUE) || (r_state == WAIT);
  assign w_match       = bus_valid_i && (bus_addr_i == r_addr) && (bus_rw_i == r_rw);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (r_state != WAIT),
    .enable (r_state == WAIT),
    .expired(w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. A match during ISSUE covers a combinational loopback and skips WAIT.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid_i)              w_next = ISSUE;
      ISSUE:   w_next = w_match ? RESP : WAIT;
      WAIT:    if (w_match || w_expired)     w_next = RESP;
      RESP:    if (resp_ready_i)             w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, response capture and mismatch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rw           <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_rw      <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_mismatch     <= 1'b0;
    end else begin
      r_mismatch <= bus_valid_i && !(w_outstanding && w_match);
      if ((r_state == IDLE) && req_valid_i) begin
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_rw    <= req_rw_i;
      end
      if (w_outstanding && w_match) begin
        r_resp_rdata   <= bus_rdata_i;
        r_resp_rw      <= r_rw;
        r_resp_timeout <= 1'b0;
      end else if ((r_state == WAIT) && w_expired) begin
        r_resp_rdata   <= '0;
        r_resp_rw      <= r_rw;
        r_resp_timeout <= 1'b1;
      end
    end
  end

  // Outputs decoded from state. Outside ISSUE the head bus holds the last launched request.
  always_comb begin
    req_ready_o    = (r_state == IDLE);
    resp_valid_o   = (r_state == RESP);
    resp_rdata_o   = r_resp_rdata;
    resp_rw_o      = r_resp_rw;
    resp_timeout_o = r_resp_timeout;
    mismatch_o     = r_mismatch;
    w_head         = '{addr: r_addr, wdata: r_wdata, rdata: '0, rw: r_rw,
                       valid: (r_state == ISSUE)};
    bus_addr_o     = w_head.addr;
    bus_wdata_o    = w_head.wdata;
    bus_rdata_o    = w_head.rdata;
    bus_rw_o       = w_head.rw;
    bus_valid_o    = w_head.valid;
  end

endmodule
